countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 20 ++
 rtl/countdown_timer_if.sv | 27 ++
 rtl/countdown_timer_mod60_down.sv | 34 +++
 rtl/countdown_timer.sv | 109 ++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_pkg;

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] SEC_MAX = CNT_W'(59);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Saturate a preset value at its legal maximum.
  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v,
                                             input logic [CNT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle between the timer and its controller.
interface countdown_timer_if;
  import countdown_pkg::*;

  logic             tick;
  logic             load;
  logic [CNT_W-1:0] load_min;
  logic [CNT_W-1:0] load_sec;
  logic             start;
  logic             pause;
  logic [CNT_W-1:0] minutes;
  logic [CNT_W-1:0] seconds;
  logic             running;
  logic             borrow;
  logic             done;

  modport master (
    output tick, load, load_min, load_sec, start, pause,
    input  minutes, seconds, running, borrow, done
  );

  modport slave (
    input  tick, load, load_min, load_sec, start, pause,
    output minutes, seconds, running, borrow, done
  );

endinterface

// File: rtl/countdown_timer_mod60_down.sv
// 0..59 down-counter: wraps 0 -> 59 with a one-cycle borrow pulse.
module mod60_down
  import countdown_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] sec,
  output logic             borrow
);

  // Load wins over decrement; borrow is only ever high for the wrapping edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec    <= '0;
      borrow <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (ld) begin
        sec <= ld_val;
      end else if (en) begin
        if (sec == '0) begin
          sec    <= SEC_MAX;
          borrow <= 1'b1;
        end else begin
          sec <= sec - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: minutes and control FSM here, seconds in mod60_down.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MAX_MIN);

  state_t           state;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] sec_q;
  logic             running_q;
  logic             done_q;
  logic             borrow_q;

  logic             sec_zero_c;
  logic             min_zero_c;
  logic             count_zero_c;
  logic             sec_en_c;
  logic [CNT_W-1:0] sec_ld_val_c;

  // Count status and the seconds enable: a tick only counts in RUN when
  // neither load nor pause claims the edge, and never below 00:00.
  always_comb begin
    sec_zero_c   = (sec_q == '0);
    min_zero_c   = (min_q == '0);
    count_zero_c = sec_zero_c && min_zero_c;
    sec_en_c     = (state == RUN) && bus.tick && !bus.pause && !bus.load &&
                   !count_zero_c;
    sec_ld_val_c = clamp(bus.load_sec, SEC_MAX);
  end

  mod60_down u_sec (
    .clk    (clk),
    .reset  (reset),
    .en     (sec_en_c),
    .ld     (bus.load),
    .ld_val (sec_ld_val_c),
    .sec    (sec_q),
    .borrow (borrow_q)
  );

  // Control FSM with minutes count; priority load > pause > start > tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      min_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        state     <= IDLE;
        min_q     <= clamp(bus.load_min, MIN_LIM);
        running_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !count_zero_c) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end else if (bus.tick && !count_zero_c) begin
              if (sec_zero_c) begin
                min_q <= min_q - CNT_W'(1);
              end
              if (min_zero_c && (sec_q == CNT_W'(1))) begin
                state     <= EXPIRED;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (bus.start && !bus.pause && !count_zero_c) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          EXPIRED: begin
            state <= EXPIRED;
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered status out to the bus.
  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.running = running_q;
  assign bus.borrow  = borrow_q;
  assign bus.done    = done_q;

endmodule
